// File: rtl/spi_mem_pkg.sv
// Shared SPI memory protocol definitions, common to the responder and the
// initiator-side controller.
package spi_mem_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RDATA,
    WDATA,
    IGNORE
  } spi_state_e;

endpackage

// File: rtl/spi_mem_responder_if.sv
// SPI target pins plus byte-wide SRAM port of the SPI memory responder.
interface spi_mem_responder_if #(
  parameter int MEM_AW = 13
);

  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              cmd_err;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, mem_rdata,
    output spi_miso, mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, mem_rdata,
    input  spi_miso, mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a third stage for rise/fall detection of an
// asynchronous input.
module spi_sync_edge #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      sync_p2 <= RST_VAL;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~sync_p2;
  assign fall  = ~sync_p1 & sync_p2;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory target: decodes command and 24-bit address, then streams
// bytes between the oversampled SPI pins and a byte-wide synchronous SRAM.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int MEM_AW   = 13,
  parameter bit WRITE_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  spi_mem_responder_if.slave bus
);

  localparam int CW = $clog2(ADDR_BITS);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_BITS - 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_p0, mosi_p1;
  logic unused_sync;

  spi_state_e        state;
  logic [CW-1:0]     cnt;
  logic [6:0]        rx_sh;
  logic [7:0]        tx;
  logic [MEM_AW-1:0] addr;
  logic              rd;
  logic              ld_pend;

  logic              miso_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              mem_we_q, mem_re_q, busy_q, cmd_err_q;

  logic [7:0]        rx_byte;
  logic [MEM_AW-1:0] addr_shift, addr_inc;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(bus.spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  // cs_n idles high so a reset does not fake a select
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(bus.spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  assign unused_sync = sclk_lvl ^ cs_fall;

  // mosi stage p0/p1, aligned with the sclk level used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      mosi_p0 <= bus.spi_mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign rx_byte    = {rx_sh, mosi_p1};
  assign addr_shift = {addr[MEM_AW-2:0], mosi_p1};
  assign addr_inc   = addr + MEM_AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rx_sh       <= '0;
      tx          <= '0;
      addr        <= '0;
      rd          <= 1'b0;
      ld_pend     <= 1'b0;
      miso_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      ld_pend   <= mem_re_q;
      if (state != IDLE && cs_rise) begin
        state   <= IDLE;
        busy_q  <= 1'b0;
        cnt     <= '0;
        miso_q  <= 1'b0;
        ld_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!cs_lvl) begin
              state  <= CMD;
              cnt    <= '0;
              busy_q <= 1'b1;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              rx_sh <= rx_byte[6:0];
              cnt   <= cnt + CW'(1);
              if (cnt == CMD_LAST) begin
                cnt <= '0;
                if (rx_byte == SPI_CMD_READ) begin
                  state <= ADDR;
                  rd    <= 1'b1;
                end else if (WRITE_EN && rx_byte == SPI_CMD_WRITE) begin
                  state <= ADDR;
                  rd    <= 1'b0;
                end else begin
                  state     <= IGNORE;
                  cmd_err_q <= 1'b1;
                end
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              addr <= addr_shift;
              cnt  <= cnt + CW'(1);
              if (cnt == ADDR_LAST) begin
                cnt <= '0;
                if (rd) begin
                  mem_re_q   <= 1'b1;
                  mem_addr_q <= addr_shift;
                  state      <= RDATA;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            // SRAM data lands two cycles after the strobe, ahead of the next fall
            if (ld_pend) begin
              tx <= bus.mem_rdata;
            end else if (sclk_fall) begin
              miso_q <= tx[7];
              tx     <= {tx[6:0], 1'b0};
            end
            if (sclk_rise) begin
              cnt <= cnt + CW'(1);
              if (cnt == DATA_LAST) begin
                cnt        <= '0;
                addr       <= addr_inc;
                mem_re_q   <= 1'b1;
                mem_addr_q <= addr_inc;
              end
            end
          end
          WDATA: begin
            if (sclk_rise) begin
              rx_sh <= rx_byte[6:0];
              cnt   <= cnt + CW'(1);
              if (cnt == DATA_LAST) begin
                cnt         <= '0;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= addr;
                mem_wdata_q <= rx_byte;
                addr        <= addr_inc;
              end
            end
          end
          IGNORE: begin
            miso_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.spi_miso  = miso_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Scoreboard bench for spi_mem_responder: acts as SPI initiator and SRAM,
// checking strobes, MISO bytes and status against queued expectations.
module tb_spi_mem_responder;
  import spi_mem_pkg::*;

  localparam int AW = 13;
  localparam int HP = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_mem_responder_if #(.MEM_AW(AW)) bus ();

  spi_mem_responder #(.MEM_AW(AW), .WRITE_EN(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr];
    if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
  end

  logic [AW+7:0] exp_we [$];
  logic [AW-1:0] exp_re [$];
  logic [7:0]    exp_rx [$];
  int n_chk = 0, n_fail = 0;
  int we_cnt = 0, re_cnt = 0, err_cnt = 0;
  logic [AW+7:0] we_e;
  logic [AW-1:0] re_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we || bus.mem_re) chk("strobe_excl", 32'(bus.mem_we & bus.mem_re), 32'd0);
      if (bus.mem_we) begin
        we_cnt++;
        if (exp_we.size() == 0) chk("we_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
        else begin
          we_e = exp_we.pop_front();
          chk("we_addr", 32'(bus.mem_addr), 32'(we_e[AW+7:8]));
          chk("we_data", 32'(bus.mem_wdata), 32'(we_e[7:0]));
        end
      end
      if (bus.mem_re) begin
        re_cnt++;
        if (exp_re.size() == 0) chk("re_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
        else begin
          re_e = exp_re.pop_front();
          chk("re_addr", 32'(bus.mem_addr), 32'(re_e));
        end
      end
      if (bus.cmd_err) err_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_shift(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      tick(HP);
      rx[i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      tick(HP);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input bit check_rx, input string tag,
                          output logic [7:0] rx);
    logic [7:0] e;
    spi_shift(tx, 8, rx);
    if (check_rx) begin
      if (exp_rx.size() != 0) e = exp_rx.pop_front();
      else e = 8'hxx;
      chk(tag, 32'(rx), 32'(e));
    end
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] rx;
    spi_byte(cmd, 1'b0, "", rx);
    spi_byte(a[23:16], 1'b0, "", rx);
    spi_byte(a[15:8], 1'b0, "", rx);
    spi_byte(a[7:0], 1'b0, "", rx);
  endtask

  task automatic cs_start();
    bus.spi_cs_n = 1'b0;
    tick(HP);
    chk("busy_rise", 32'(bus.busy), 32'd1);
  endtask

  task automatic cs_stop(input string tag);
    int n;
    n = 0;
    tick(HP);
    bus.spi_cs_n = 1'b1;
    while (bus.busy && n < 20) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(n <= 3), 32'd1);
    tick(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx;
    logic [31:0] word, word_rd;
    int e0, r0, w0;

    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    rst = 1'b1;
    tick(5);
    chk("rst_miso",  32'(bus.spi_miso), 32'd0);
    chk("rst_we",    32'(bus.mem_we), 32'd0);
    chk("rst_re",    32'(bus.mem_re), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_err",   32'(bus.cmd_err), 32'd0);
    chk("rst_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    rst = 1'b0;

    // idle SCLK/MOSI activity with CS deasserted
    for (int i = 0; i < 100; i++) begin
      bus.spi_sclk = ~bus.spi_sclk;
      bus.spi_mosi = 1'($urandom_range(0, 1));
      tick(1);
    end
    bus.spi_sclk = 1'b0;
    tick(4);
    chk("idle_we",   32'(we_cnt), 32'd0);
    chk("idle_re",   32'(re_cnt), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_err",  32'(err_cnt), 32'd0);

    // single write
    exp_we.push_back({13'h0010, 8'hA5});
    cs_start();
    send_hdr(SPI_CMD_WRITE, 24'h000010);
    spi_byte(8'hA5, 1'b0, "", rx);
    cs_stop("wr_busy_fall");
    chk("wr_we_cnt", 32'(we_cnt), 32'd1);

    // write across the wrap point, then read it back as a burst
    exp_we.push_back({13'h1FFF, 8'h11});
    exp_we.push_back({13'h0000, 8'h22});
    cs_start();
    send_hdr(SPI_CMD_WRITE, 24'h001FFF);
    spi_byte(8'h11, 1'b0, "", rx);
    spi_byte(8'h22, 1'b0, "", rx);
    cs_stop("wrap_wr_busy_fall");
    chk("wrap_we_cnt", 32'(we_cnt), 32'd3);

    exp_re.push_back(13'h1FFF);
    exp_re.push_back(13'h0000);
    exp_re.push_back(13'h0001);
    exp_rx.push_back(8'h11);
    exp_rx.push_back(8'h22);
    r0 = re_cnt;
    cs_start();
    send_hdr(SPI_CMD_READ, 24'h001FFF);
    spi_byte(8'h00, 1'b1, "rd_wrap_b0", rx);
    spi_byte(8'h00, 1'b1, "rd_wrap_b1", rx);
    cs_stop("rd_wrap_busy_fall");
    chk("rd_wrap_re_cnt", 32'(re_cnt - r0), 32'd3);

    // word round-trip
    word = 32'hDEADBEEF;
    for (int b = 0; b < 4; b++)
      exp_we.push_back({13'(13'h0100 + b), word[31-8*b -: 8]});
    cs_start();
    send_hdr(SPI_CMD_WRITE, 24'h000100);
    for (int b = 0; b < 4; b++) spi_byte(word[31-8*b -: 8], 1'b0, "", rx);
    cs_stop("rt_wr_busy_fall");
    chk("rt_we_cnt", 32'(we_cnt), 32'd7);

    for (int b = 0; b < 5; b++) exp_re.push_back(13'(13'h0100 + b));
    for (int b = 0; b < 4; b++) exp_rx.push_back(word[31-8*b -: 8]);
    word_rd = '0;
    cs_start();
    send_hdr(SPI_CMD_READ, 24'h000100);
    for (int b = 0; b < 4; b++) begin
      spi_byte(8'h00, 1'b1, "rt_rd_byte", rx);
      word_rd = {word_rd[23:0], rx};
    end
    cs_stop("rt_rd_busy_fall");
    chk("rt_word", word_rd, 32'hDEADBEEF);

    // unknown command
    e0 = err_cnt; r0 = re_cnt; w0 = we_cnt;
    cs_start();
    spi_byte(8'h9F, 1'b0, "", rx);
    chk("unk_miso_cmd", 32'(rx), 32'd0);
    tick(2);
    chk("unk_err_pulse", 32'(err_cnt - e0), 32'd1);
    for (int b = 0; b < 4; b++) begin
      exp_rx.push_back(8'h00);
      spi_byte(8'($urandom), 1'b1, "unk_miso", rx);
    end
    cs_stop("unk_busy_fall");
    chk("unk_err_once", 32'(err_cnt - e0), 32'd1);
    chk("unk_no_re", 32'(re_cnt - r0), 32'd0);
    chk("unk_no_we", 32'(we_cnt - w0), 32'd0);

    // abort mid-write, then a clean read of the stored byte
    w0 = we_cnt;
    exp_we.push_back({13'h0020, 8'h3C});
    cs_start();
    send_hdr(SPI_CMD_WRITE, 24'h000020);
    spi_byte(8'h3C, 1'b0, "", rx);
    spi_shift(8'hFF, 5, rx);
    cs_stop("abort_busy_fall");
    tick(20);
    chk("abort_we_cnt", 32'(we_cnt - w0), 32'd1);

    r0 = re_cnt;
    exp_re.push_back(13'h0020);
    exp_re.push_back(13'h0021);
    exp_rx.push_back(8'h3C);
    cs_start();
    send_hdr(SPI_CMD_READ, 24'h000020);
    spi_byte(8'h00, 1'b1, "abort_readback", rx);
    cs_stop("abort_rd_busy_fall");
    chk("abort_rd_re_cnt", 32'(re_cnt - r0), 32'd2);

    tick(10);
    chk("we_q_drained", 32'(exp_we.size()), 32'd0);
    chk("re_q_drained", 32'(exp_re.size()), 32'd0);
    chk("rx_q_drained", 32'(exp_rx.size()), 32'd0);
    chk("final_err_cnt", 32'(err_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
- SPI mode-0 target that answers the SoC's SPI memory initiator on the shared bus.
- Decodes the 8-bit command and 24-bit address, then streams data bytes to or from a byte-wide synchronous SRAM port.
- Used as the synthesizable on-chip stand-in for the external SPI RAM/flash, both in FPGA builds and as a cycle-accurate bench target.
- Runs entirely in the system clock domain; SCLK, CS_N and MOSI are oversampled.

Parameters:
- MEM_AW, 13, byte-address width of the backing SRAM. The low MEM_AW bits of the 24-bit SPI address are used, and addresses wrap modulo 2^MEM_AW.
- WRITE_EN, 1, enables the write command (0x02). When 0, the write command is treated as unknown, which is the flash-style target.

Ports:
- clk, input, 1: system clock. Must be at least 8x the SCLK frequency.
- rst, input, 1: reset. Asynchronous, active-high.
- spi_sclk, input, 1: SPI clock from the initiator. Asynchronous.
- spi_cs_n, input, 1: chip select, active-low. Asynchronous.
- spi_mosi, input, 1: serial data in, MSB first.
- spi_miso, output, 1: serial data out. Driven 0 when not selected.
- mem_addr, output, MEM_AW: SRAM byte address.
- mem_wdata, output, 8: SRAM write data.
- mem_we, output, 1: SRAM write strobe, 1-cycle pulse.
- mem_re, output, 1: SRAM read strobe, 1-cycle pulse. Data is valid on mem_rdata the next cycle.
- mem_rdata, input, 8: SRAM read data.
- busy, output, 1: high from CS_N fall (synchronized) to CS_N rise (synchronized).
- cmd_err, output, 1: 1-cycle pulse when an unknown command byte completes.

Behaviour:
- Input sampling:
  - 2-flop synchronizers on sclk, cs_n and mosi.
  - A third register provides edge detection.
  - Rising SCLK edge: sample mosi. Falling SCLK edge: shift miso.
- Reset values: spi_miso=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, cmd_err=0. State=IDLE; bit counter, shift registers and address register all 0.
- IDLE:
  - On synchronized cs_n=0, go to CMD, clear the bit counter, set busy=1.
- CMD:
  - Shift 8 bits in.
  - After the 8th rising edge, a cmd of 0x03 goes to ADDR with rd=1.
  - A cmd of 0x02 with WRITE_EN=1 goes to ADDR with rd=0.
  - Any other value pulses cmd_err and goes to IGNORE.
- ADDR:
  - Shift 24 bits in. Latch addr = low MEM_AW bits.
  - Read case: on the cycle after the 24th rising edge, pulse mem_re with mem_addr=addr. Load the tx shift register from mem_rdata one cycle later, then go to RDATA.
  - Write case: go to WDATA.
- RDATA:
  - On each falling edge, drive spi_miso = tx[7] and shift left.
  - The first data bit appears on the first falling edge after the last address bit.
  - On the rising edge of bit 7 of each byte: addr <= addr+1 (wraps), pulse mem_re at the new addr, and reload tx from mem_rdata before the next falling edge.
  - Streaming is unbounded until CS rises.
- WDATA:
  - Assemble 8 bits per byte.
  - On the cycle after the 8th rising edge, pulse mem_we with mem_addr=addr and mem_wdata=byte, then addr <= addr+1 (wraps).
  - A partial byte is discarded when CS rises.
- IGNORE:
  - spi_miso held 0. All SCLK edges are ignored until CS rises.
- CS rise (synchronized), from any state:
  - Return to IDLE the same cycle and set busy=0.
  - No pending strobe is issued and the bit counter clears.
  - A mem_we already issued for a complete byte stands.
- cs_n low during reset release: treated as a new transaction starting at the next synchronized sample.
- SCLK edges while cs_n is high are ignored.
- mem_we and mem_re are never high in the same cycle.
- Latency budget: the read reload must complete within half an SCLK period. This is guaranteed by the 8x clock ratio: 3 cycles of synchronizer/edge delay plus 1 cycle of SRAM latency, and each half-period is at least 4 cycles.

Decomposition:
- Shared package `spi_mem_pkg`:
  - Command constants SPI_CMD_READ=8'h03 and SPI_CMD_WRITE=8'h02.
  - State encoding IDLE/CMD/ADDR/RDATA/WDATA/IGNORE.
  - CMD_BITS=8 and ADDR_BITS=24.
  - These are shared with the initiator-side controller.
- One sub-module, `spi_sync_edge`: 2-flop synchronizer plus edge detector, giving outputs level, rise and fall. It is instanced for sclk and cs_n; mosi uses a plain synchronizer.

Test Plan:
- Reset then idle: assert rst with cs_n=1 -> all outputs 0 and busy=0. No mem strobes after 100 cycles of idle SCLK toggling.
- Single write: send 0x02, 0x000010, 0xA5 -> exactly one mem_we with mem_addr=0x0010 and mem_wdata=0xA5. busy falls within 3 cycles of CS rise.
- Burst read with wrap (MEM_AW=13): preload SRAM[0x1FFF]=0x11 and [0x0000]=0x22, send 0x03, 0x001FFF, clock 16 bits -> MISO returns 0x11 then 0x22. mem_re addresses are 0x1FFF then 0x0000.
- Word round-trip against the initiator: store word 0xDEADBEEF at 0x000100, then read 4 bytes -> the MISO stream matches the MOSI data stream byte-for-byte. The initiator's read returns 0xDEADBEEF.
- Unknown command: send 0x9F followed by 32 clocks -> cmd_err pulses once after the 8th bit. MISO stays 0. No mem_we or mem_re.
- Abort mid-write: send 0x02, 0x000020, one full byte 0x3C, then 5 bits and raise CS -> only one mem_we (addr 0x0020, data 0x3C). The next transaction starts cleanly in CMD.
